// File: rtl/seq_detector_param_pkg.sv
// Pattern-matching helpers: KMP failure and transition functions evaluated at
// elaboration time to build the detector's constant next-state table.
package seq_det_pkg;

    localparam int SEQ_MAX_W = 16;

    function automatic int seq_st_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Longest proper prefix of the first k pattern bits that is also their suffix.
    function automatic int seq_fail(input logic [15:0] pattern, input int width, input int k);
        int  best;
        logic ok;
        best = 0;
        for (int len = 1; len < k; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                ok = ok & (pattern[width-1-i] == pattern[width-1-k+len-i]);
            end
            best = ok ? len : best;
        end
        return best;
    endfunction

    function automatic int seq_next(input logic [15:0] pattern, input int width,
                                    input int k, input logic b);
        int   j;
        int   res;
        logic done;
        j    = k;
        res  = 0;
        done = 1'b0;
        for (int it = 0; it <= SEQ_MAX_W; it++) begin
            if (!done) begin
                if ((j < width) && (b == pattern[width-1-j])) begin
                    res  = j + 1;
                    done = 1'b1;
                end else if (j == 0) begin
                    res  = 0;
                    done = 1'b1;
                end else begin
                    j = seq_fail(pattern, width, j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-input / match-output bundle between the bit source and the detector.
interface seq_det_if #(
    parameter int ST_W  = 3,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din_bit;
    logic             cnt_clr;
    logic             match;
    logic [ST_W-1:0]  state_o;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din_valid, din_bit, cnt_clr,
        input  match, state_o, match_cnt
    );

    modport slave (
        input  din_valid, din_bit, cnt_clr,
        output match, state_o, match_cnt
    );
endinterface

// File: rtl/seq_detector_param_counter.sv
// Saturating match counter with clear priority; only built with SEQ_DET_CNT_EN.
`ifdef SEQ_DET_CNT_EN
module seq_det_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule
`endif

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with registered one-cycle match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int          PAT_W   = 4,
    parameter logic [15:0] PATTERN = 16'h0006,
    parameter int          OVERLAP = 1,
    parameter int          CNT_W   = 8
) (
    input  logic   clk,
    input  logic   rst,
    seq_det_if.slave bus
);

    localparam int ST_W  = seq_st_w(PAT_W);
    localparam int TBL_N = 2 ** (ST_W + 1);
    localparam int FAIL_FULL = seq_fail(PATTERN, PAT_W, PAT_W);
    localparam logic [ST_W-1:0] FULL_ST    = PAT_W[ST_W-1:0];
    localparam logic [ST_W-1:0] RESTART_ST = (OVERLAP != 0) ? FAIL_FULL[ST_W-1:0] : {ST_W{1'b0}};

    generate
        if ((PAT_W < 2) || (PAT_W > 16)) begin : g_bad_width
            $error("seq_detector_param: PAT_W must be in 2..16");
        end
        if ((PATTERN >> PAT_W) != 16'h0000) begin : g_bad_pattern
            $error("seq_detector_param: PATTERN wider than PAT_W");
        end
    endgenerate

    // Table indexed by {state, bit}; rows beyond PAT_W-1 are unreachable.
    logic [ST_W-1:0] nxt_tbl [TBL_N];

    for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
        localparam int K  = i / 2;
        localparam int NX = (K < PAT_W) ? seq_next(PATTERN, PAT_W, K, ((i % 2) == 1)) : 0;
        assign nxt_tbl[i] = NX[ST_W-1:0];
    end

    logic [ST_W-1:0] state_r;
    logic [ST_W-1:0] nxt_s;
    logic            match_r;
    logic            hit_s;

    // Table lookup and completion detect for the bit presented this cycle.
    always_comb begin
        nxt_s = nxt_tbl[{state_r, bus.din_bit}];
        hit_s = bus.din_valid && (nxt_s == FULL_ST);
    end

    // Prefix-length state and match pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= {ST_W{1'b0}};
            match_r <= 1'b0;
        end else if (bus.din_valid) begin
            if (hit_s) begin
                state_r <= RESTART_ST;
                match_r <= 1'b1;
            end else begin
                state_r <= nxt_s;
                match_r <= 1'b0;
            end
        end else begin
            state_r <= state_r;
            match_r <= 1'b0;
        end
    end

    assign bus.match   = match_r;
    assign bus.state_o = state_r;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_s;

    seq_det_counter #(.CNT_W(CNT_W)) u_counter (
        .clk (clk),
        .rst (rst),
        .inc (hit_s),
        .clr (bus.cnt_clr),
        .cnt (cnt_s)
    );

    assign bus.match_cnt = cnt_s;
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = bus.cnt_clr;
    assign bus.match_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: three detector configurations (0110 overlap, 0110 restart, 1111 with 2-bit counter).
module tb_seq_detector_param;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    seq_det_if #(.ST_W(3), .CNT_W(8)) ifa ();
    seq_det_if #(.ST_W(3), .CNT_W(8)) ifb ();
    seq_det_if #(.ST_W(3), .CNT_W(2)) ifc ();

    seq_detector_param #(.PAT_W(4), .PATTERN(16'h0006), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    seq_detector_param #(.PAT_W(4), .PATTERN(16'h0006), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));
    seq_detector_param #(.PAT_W(4), .PATTERN(16'h000F), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk (clk), .rst (rst), .bus (ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int d, input logic b, input logic clr);
        @(negedge clk);
        case (d)
            0: begin ifa.din_valid = 1'b1; ifa.din_bit = b; ifa.cnt_clr = clr; end
            1: begin ifb.din_valid = 1'b1; ifb.din_bit = b; ifb.cnt_clr = clr; end
            default: begin ifc.din_valid = 1'b1; ifc.din_bit = b; ifc.cnt_clr = clr; end
        endcase
        @(posedge clk);
        #1;
        ifa.din_valid = 1'b0; ifa.cnt_clr = 1'b0;
        ifb.din_valid = 1'b0; ifb.cnt_clr = 1'b0;
        ifc.din_valid = 1'b0; ifc.cnt_clr = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [6:0] bits7;
    logic [6:0] m_a;
    logic [6:0] m_b;
    int         st_a [7];
    int         st_b [7];
    logic [3:0] bits4;
    int         st3  [4];
    logic [3:0] m5;
    int         c5   [7];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        ifa.din_valid = 1'b0; ifa.din_bit = 1'b0; ifa.cnt_clr = 1'b0;
        ifb.din_valid = 1'b0; ifb.din_bit = 1'b0; ifb.cnt_clr = 1'b0;
        ifc.din_valid = 1'b0; ifc.din_bit = 1'b0; ifc.cnt_clr = 1'b0;

        do_reset();
        check_eq("rst_a_state", 32'(ifa.state_o), 32'd0);
        check_eq("rst_a_match", 32'(ifa.match), 32'd0);
        check_eq("rst_b_state", 32'(ifb.state_o), 32'd0);
        check_eq("rst_c_state", 32'(ifc.state_o), 32'd0);
        check_eq("rst_c_cnt", 32'(ifc.match_cnt), 32'd0);

        // Stream 0,1,1,0,1,1,0 on overlap and restart detectors.
        bits7 = 7'b0110110;
        m_a   = 7'b0001001;
        m_b   = 7'b0001000;
        st_a  = '{1, 2, 3, 1, 2, 3, 1};
        st_b  = '{1, 2, 3, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            send(0, bits7[6-i], 1'b0);
            check_eq($sformatf("t1_match_%0d", i + 1), 32'(ifa.match), 32'(m_a[6-i]));
            check_eq($sformatf("t1_state_%0d", i + 1), 32'(ifa.state_o), 32'(st_a[i]));
        end
        for (int i = 0; i < 7; i++) begin
            send(1, bits7[6-i], 1'b0);
            check_eq($sformatf("t2_match_%0d", i + 1), 32'(ifb.match), 32'(m_b[6-i]));
            check_eq($sformatf("t2_state_%0d", i + 1), 32'(ifb.state_o), 32'(st_b[i]));
        end

        // Gapped 0110: state holds through idle cycles, match lasts one cycle.
        do_reset();
        bits4 = 4'b0110;
        st3   = '{1, 2, 3, 1};
        for (int i = 0; i < 4; i++) begin
            send(0, bits4[3-i], 1'b0);
            check_eq($sformatf("t3_match_%0d", i + 1), 32'(ifa.match), (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("t3_state_%0d", i + 1), 32'(ifa.state_o), 32'(st3[i]));
            for (int g = 0; g < 3; g++) begin
                idle_cycle();
                check_eq($sformatf("t3_gap_match_%0d_%0d", i + 1, g), 32'(ifa.match), 32'd0);
                check_eq($sformatf("t3_gap_state_%0d_%0d", i + 1, g), 32'(ifa.state_o), 32'(st3[i]));
            end
        end

        // Reset mid-pattern discards the partial prefix.
        do_reset();
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0);
        send(0, 1'b1, 1'b0);
        check_eq("t4_state_pre", 32'(ifa.state_o), 32'd3);
        do_reset();
        check_eq("t4_state_rst", 32'(ifa.state_o), 32'd0);
        send(0, 1'b0, 1'b0);
        check_eq("t4_match", 32'(ifa.match), 32'd0);
        check_eq("t4_state", 32'(ifa.state_o), 32'd1);

        // Seven 1s on 1111 overlap detector with saturating 2-bit counter.
        m5 = 4'b1111;
        c5 = '{0, 0, 0, 1, 2, 3, 3};
        for (int i = 0; i < 7; i++) begin
            send(2, 1'b1, 1'b0);
            check_eq($sformatf("t5_match_%0d", i + 1), 32'(ifc.match), (i >= 3) ? 32'(m5[i-3]) : 32'd0);
            check_eq($sformatf("t5_state_%0d", i + 1), 32'(ifc.state_o), (i >= 2) ? 32'd3 : 32'(i + 1));
            check_eq($sformatf("t5_cnt_%0d", i + 1), 32'(ifc.match_cnt), CNT_ON ? 32'(c5[i]) : 32'd0);
        end

        // Clear wins over a same-cycle increment.
        send(2, 1'b1, 1'b1);
        check_eq("t6_match_clr", 32'(ifc.match), 32'd1);
        check_eq("t6_cnt_clr", 32'(ifc.match_cnt), 32'd0);
        send(2, 1'b1, 1'b0);
        check_eq("t6_cnt_inc", 32'(ifc.match_cnt), CNT_ON ? 32'd1 : 32'd0);
        idle_cycle();
        check_eq("t6_idle_match", 32'(ifc.match), 32'd0);
        check_eq("t6_idle_cnt", 32'(ifc.match_cnt), CNT_ON ? 32'd1 : 32'd0);
        do_reset();
        check_eq("t6_rst_cnt", 32'(ifc.match_cnt), 32'd0);
        check_eq("t6_rst_state", 32'(ifc.state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
